// File: rtl/uart_rx_cfg.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_cfg
// Desc     : Oversampling UART receiver with runtime parity/stop configuration,
//            3-sample majority vote, error flags and a valid/ready output.
// Revision : 1.0
// ============================================================================
module uart_rx_cfg #(
   parameter int DBITS  = 8,
   parameter int SAMPLE = 16,
   parameter int CW     = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             tick,
   input  logic             rx,
   input  logic [1:0]       cfg_parity,
   input  logic             cfg_stop2,
   output logic [DBITS-1:0] dout,
   output logic             rx_valid,
   input  logic             rx_ready,
   output logic             parity_err,
   output logic             frame_err,
   output logic             break_det,
   output logic             overrun,
   output logic             busy
);

   localparam int              c_BW       = (DBITS > 1) ? $clog2(DBITS) : 1;
   localparam logic [CW-1:0]   c_VOTE_A   = CW'(SAMPLE/2 - 1);
   localparam logic [CW-1:0]   c_VOTE_B   = CW'(SAMPLE/2);
   localparam logic [CW-1:0]   c_VOTE_D   = CW'(SAMPLE/2 + 1);
   localparam logic [CW-1:0]   c_CNT_LAST = CW'(SAMPLE - 1);
   localparam logic [CW-1:0]   c_CNT_ONE  = CW'(1);
   localparam logic [c_BW-1:0] c_BIT_LAST = c_BW'(DBITS - 1);
   localparam logic [c_BW-1:0] c_BIT_ONE  = c_BW'(1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } state_t;

   state_t            r_state, w_state_nxt;
   logic              r_rx_meta, r_rx_s;
   logic [CW-1:0]     r_cnt;
   logic [c_BW-1:0]   r_bitn;
   logic [DBITS-1:0]  r_shift;
   logic              r_smp_a, r_smp_b;
   logic              r_par_en, r_par_odd, r_stop2, r_stop_n;
   logic              r_perr_f, r_stop1_low, r_pbit;
   logic [DBITS-1:0]  r_dout;
   logic              r_valid, r_perr, r_ferr, r_brk, r_ovr;

   logic w_vote, w_at_vote, w_wrap;
   logic w_start, w_shift, w_par_chk, w_stop_chk, w_commit;
   logic w_first_low, w_ferr, w_brk;

   assign w_vote    = (r_smp_a & r_smp_b) | (r_smp_a & r_rx_s) | (r_smp_b & r_rx_s);
   assign w_at_vote = tick && (r_cnt == c_VOTE_D);
   assign w_wrap    = tick && (r_cnt == c_CNT_LAST);

   // With two stop bits the first one's level was latched a bit period earlier.
   assign w_first_low = r_stop_n ? r_stop1_low : ~w_vote;
   assign w_ferr      = w_first_low | ~w_vote;
   assign w_brk       = (r_shift == '0) && (!r_par_en || !r_pbit) && w_first_low;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rx_meta <= 1'b1;
         r_rx_s    <= 1'b1;
      end else begin
         r_rx_meta <= rx;
         r_rx_s    <= r_rx_meta;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_start     = 1'b0;
      w_shift     = 1'b0;
      w_par_chk   = 1'b0;
      w_stop_chk  = 1'b0;
      w_commit    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (tick && !r_rx_s) begin
               w_state_nxt = S_START;
               w_start     = 1'b1;
            end
         end
         S_START: begin
            if (w_at_vote && w_vote) w_state_nxt = S_IDLE;
            else if (w_wrap)         w_state_nxt = S_DATA;
         end
         S_DATA: begin
            w_shift = w_at_vote;
            if (w_wrap && (r_bitn == c_BIT_LAST))
               w_state_nxt = r_par_en ? S_PARITY : S_STOP;
         end
         S_PARITY: begin
            w_par_chk = w_at_vote;
            if (w_wrap) w_state_nxt = S_STOP;
         end
         S_STOP: begin
            if (w_at_vote) begin
               w_stop_chk = 1'b1;
               if (!r_stop2 || r_stop_n) begin
                  w_commit    = 1'b1;
                  w_state_nxt = S_IDLE;
               end
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt       <= '0;
         r_bitn      <= '0;
         r_shift     <= '0;
         r_smp_a     <= 1'b1;
         r_smp_b     <= 1'b1;
         r_par_en    <= 1'b0;
         r_par_odd   <= 1'b0;
         r_stop2     <= 1'b0;
         r_stop_n    <= 1'b0;
         r_perr_f    <= 1'b0;
         r_stop1_low <= 1'b0;
         r_pbit      <= 1'b0;
      end else begin
         if (w_state_nxt != r_state)
            r_cnt <= '0;
         else if (tick && (r_state != S_IDLE))
            r_cnt <= (r_cnt == c_CNT_LAST) ? '0 : r_cnt + c_CNT_ONE;
         if (tick && (r_cnt == c_VOTE_A)) r_smp_a <= r_rx_s;
         if (tick && (r_cnt == c_VOTE_B)) r_smp_b <= r_rx_s;
         if (w_start) begin
            r_par_en    <= (cfg_parity == 2'd1) || (cfg_parity == 2'd2);
            r_par_odd   <= (cfg_parity == 2'd2);
            r_stop2     <= cfg_stop2;
            r_stop_n    <= 1'b0;
            r_bitn      <= '0;
            r_perr_f    <= 1'b0;
            r_stop1_low <= 1'b0;
            r_pbit      <= 1'b0;
         end
         if (w_shift) r_shift <= {w_vote, r_shift[DBITS-1:1]};
         if ((r_state == S_DATA) && w_wrap) r_bitn <= r_bitn + c_BIT_ONE;
         if (w_par_chk) begin
            r_pbit   <= w_vote;
            r_perr_f <= w_vote != ((^r_shift) ^ r_par_odd);
         end
         if (w_stop_chk && !r_stop_n) r_stop1_low <= ~w_vote;
         if ((r_state == S_STOP) && w_wrap) r_stop_n <= 1'b1;
      end
   end

   // Commit and accept in the same cycle keeps rx_valid high with fresh data.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_dout  <= '0;
         r_valid <= 1'b0;
         r_perr  <= 1'b0;
         r_ferr  <= 1'b0;
         r_brk   <= 1'b0;
         r_ovr   <= 1'b0;
      end else if (w_commit) begin
         r_dout  <= r_shift;
         r_perr  <= r_par_en & r_perr_f;
         r_ferr  <= w_ferr;
         r_brk   <= w_brk;
         r_ovr   <= r_valid && !rx_ready;
         r_valid <= 1'b1;
      end else if (r_valid && rx_ready) begin
         r_valid <= 1'b0;
      end
   end

   assign dout       = r_dout;
   assign rx_valid   = r_valid;
   assign parity_err = r_perr;
   assign frame_err  = r_ferr;
   assign break_det  = r_brk;
   assign overrun    = r_ovr;
   assign busy       = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_cfg.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_cfg
// Desc     : Frame-level reference model bench for uart_rx_cfg.
// Revision : 1.0
// ============================================================================
module tb_uart_rx_cfg;

   localparam int DBITS  = 8;
   localparam int SAMPLE = 16;
   localparam int CW     = 5;
   localparam int EV_NONE = 0, EV_START = 1, EV_FALSE = 2, EV_COMMIT = 3;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       tick = 1'b0;
   logic       rx = 1'b1;
   logic [1:0] cfg_parity = 2'd0;
   logic       cfg_stop2 = 1'b0;
   logic       rx_ready = 1'b0;
   logic [DBITS-1:0] dout;
   logic rx_valid, parity_err, frame_err, break_det, overrun, busy;

   int n_checks = 0;
   int n_fail   = 0;
   bit cmp_en   = 1'b0;
   int rdy_mode = 0;

   logic [7:0] m_dout = '0;
   logic m_valid = 0, m_perr = 0, m_ferr = 0, m_brk = 0, m_ovr = 0, m_busy = 0;
   logic [7:0] e_dout = '0;
   logic e_perr = 0, e_ferr = 0, e_brk = 0;

   uart_rx_cfg #(.DBITS(DBITS), .SAMPLE(SAMPLE), .CW(CW)) dut (
      .clk(clk), .rst(rst), .tick(tick), .rx(rx),
      .cfg_parity(cfg_parity), .cfg_stop2(cfg_stop2),
      .dout(dout), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .parity_err(parity_err), .frame_err(frame_err), .break_det(break_det),
      .overrun(overrun), .busy(busy)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (cmp_en) begin
         n_checks++;
         if ({dout, rx_valid, parity_err, frame_err, break_det, overrun, busy} !==
             {m_dout, m_valid, m_perr, m_ferr, m_brk, m_ovr, m_busy}) begin
            n_fail++;
            $display("FAIL cycle t=%0t got dout=%h v=%b pe=%b fe=%b bk=%b ov=%b busy=%b exp dout=%h v=%b pe=%b fe=%b bk=%b ov=%b busy=%b",
                     $time, dout, rx_valid, parity_err, frame_err, break_det, overrun, busy,
                     m_dout, m_valid, m_perr, m_ferr, m_brk, m_ovr, m_busy);
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
      end
   endtask

   // One clock; the model advances with what the DUT saw at this edge.
   task automatic cyc(input logic tk, input int ev);
      tick = tk;
      @(posedge clk);
      if (rst) begin
         m_dout = '0; m_valid = 0; m_perr = 0; m_ferr = 0; m_brk = 0; m_ovr = 0; m_busy = 0;
      end else begin
         if (ev == EV_COMMIT) begin
            m_ovr   = m_valid && !rx_ready;
            m_valid = 1'b1;
            m_dout  = e_dout;
            m_perr  = e_perr;
            m_ferr  = e_ferr;
            m_brk   = e_brk;
            m_busy  = 1'b0;
         end else if (m_valid && rx_ready) begin
            m_valid = 1'b0;
         end
         if (ev == EV_START) m_busy = 1'b1;
         if (ev == EV_FALSE) m_busy = 1'b0;
      end
      #1;
      tick = 1'b0;
      case (rdy_mode)
         1:       rx_ready = 1'($urandom_range(0, 1));
         3:       rx_ready = 1'b1;
         default: rx_ready = 1'b0;
      endcase
   endtask

   // One oversample period: line level held for 4 clocks, tick on the last.
   task automatic slot(input logic lvl, input int ev, input bit rdy_at_tick);
      rx = lvl;
      repeat (3) cyc(1'b0, EV_NONE);
      if (rdy_at_tick) rx_ready = 1'b1;
      cyc(1'b1, ev);
   endtask

   task automatic idle(input int n);
      repeat (n) slot(1'b1, EV_NONE, 1'b0);
   endtask

   task automatic accept();
      rx_ready = 1'b1;
      cyc(1'b0, EV_NONE);
      @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic [1:0] pm, input bit s2,
                             input bit pinv, input bit st1, input bit st2,
                             input bit glitch, input int abort_slot);
      bit   pen, odd, pbit;
      logic bits[$];
      int   nb, last, g, s;
      logic lvl;
      pen  = (pm == 2'd1) || (pm == 2'd2);
      odd  = (pm == 2'd2);
      pbit = pen ? ((^d) ^ odd ^ pinv) : 1'b0;
      bits = {};
      bits.push_back(1'b0);
      for (int i = 0; i < 8; i++) bits.push_back(d[i]);
      if (pen) bits.push_back(pbit);
      bits.push_back(st1);
      if (s2) bits.push_back(st2);
      nb   = bits.size();
      // Final stop decision falls 2 ticks past mid-bit; line released right after.
      last = (nb - 1) * SAMPLE + SAMPLE/2 + 2;
      e_dout = d;
      e_perr = pen && (pbit != ((^d) ^ odd));
      e_ferr = !st1 || (s2 && !st2);
      e_brk  = (d == 8'h00) && (!pen || !pbit) && !st1;
      cfg_parity = pm;
      cfg_stop2  = s2;
      for (int b = 0; b < nb; b++) begin
         g = (glitch && b >= 1 && b <= 8) ? int'($urandom_range(1, SAMPLE - 1)) : -1;
         for (int t = 0; t < SAMPLE; t++) begin
            s = b * SAMPLE + t;
            if (s > last) break;
            if (s == abort_slot) begin
               rst = 1'b1;
               cyc(1'b0, EV_NONE);
               rst = 1'b0;
               rx  = 1'b1;
               return;
            end
            lvl = bits[b];
            if (t == g) lvl = ~lvl;
            slot(lvl, (s == 0) ? EV_START : ((s == last) ? EV_COMMIT : EV_NONE),
                 (s == last) && (rdy_mode == 2));
            if (s == 0) begin
               cfg_parity = 2'($urandom);
               cfg_stop2  = 1'($urandom);
            end
         end
      end
      rx = 1'b1;
   endtask

   task automatic false_start();
      for (int s = 0; s < SAMPLE; s++)
         slot((s < 6) ? 1'b0 : 1'b1,
              (s == 0) ? EV_START : ((s == SAMPLE/2 + 2) ? EV_FALSE : EV_NONE), 1'b0);
   endtask

   initial begin
      rdy_mode = 0;
      repeat (3) cyc(1'b0, EV_NONE);
      cmp_en = 1'b1;
      rst    = 1'b0;
      @(negedge clk);
      chk("reset_outs", 32'({dout, rx_valid, parity_err, frame_err, break_det, overrun, busy}), 32'h0);

      idle(2);
      send_frame(8'hA5, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, -1);
      @(negedge clk);
      chk("a5_dout", 32'(dout), 32'hA5);
      chk("a5_flags", 32'({rx_valid, parity_err, frame_err, break_det, overrun}), 32'h10);
      accept();
      chk("a5_accept", 32'(rx_valid), 32'h0);

      idle(3);
      send_frame(8'h07, 2'd1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, -1);
      @(negedge clk);
      chk("even_ok_perr", 32'(parity_err), 32'h0);
      accept();
      idle(2);
      send_frame(8'h07, 2'd1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, -1);
      @(negedge clk);
      chk("even_bad_perr", 32'(parity_err), 32'h1);
      chk("even_bad_dout", 32'(dout), 32'h07);
      accept();
      idle(2);
      send_frame(8'h07, 2'd2, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, -1);
      @(negedge clk);
      chk("odd_ok_perr", 32'(parity_err), 32'h0);
      accept();

      idle(2);
      false_start();
      @(negedge clk);
      chk("false_start", 32'({rx_valid, busy}), 32'h0);
      idle(2);
      send_frame(8'h3C, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, -1);
      @(negedge clk);
      chk("glitch_dout", 32'(dout), 32'h3C);
      accept();

      idle(2);
      send_frame(8'h55, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, -1);
      @(negedge clk);
      chk("stop2_ferr", 32'({frame_err, break_det}), 32'h2);
      accept();
      idle(2);
      send_frame(8'h00, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, -1);
      @(negedge clk);
      chk("break", 32'({dout, frame_err, break_det}), 32'h3);
      accept();

      idle(2);
      send_frame(8'h11, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, -1);
      idle(3);
      send_frame(8'h22, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, -1);
      @(negedge clk);
      chk("overrun", 32'({dout, rx_valid, overrun}), 32'h8B);
      rdy_mode = 2;
      idle(2);
      send_frame(8'h5A, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, -1);
      @(negedge clk);
      chk("commit_accept", 32'({dout, rx_valid, overrun}), 32'h16A);
      rdy_mode = 0;
      accept();

      idle(2);
      send_frame(8'hC3, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3 * SAMPLE + 5);
      @(negedge clk);
      chk("rst_mid", 32'({dout, rx_valid, parity_err, frame_err, break_det, overrun, busy}), 32'h0);
      idle(2);
      send_frame(8'h81, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, -1);
      @(negedge clk);
      chk("after_rst", 32'(dout), 32'h81);
      accept();

      rdy_mode = 1;
      repeat (30) begin
         send_frame(8'($urandom), 2'($urandom), 1'($urandom),
                    $urandom_range(0, 3) == 0, $urandom_range(0, 7) != 0,
                    $urandom_range(0, 7) != 0, 1'($urandom), -1);
         idle($urandom_range(1, 6));
      end
      rdy_mode = 0;
      idle(2);
      @(negedge clk);
      cmp_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
